ring_monitor: RTL and testbench

RING_MONITOR -- requirements
Module: ring_monitor

---
 rtl/ring_monitor.sv | 149 ++++++++++++++
 tb/tb_ring_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_monitor.sv
// ring_monitor: watches a 4-bit one-hot ring counter, declares lock after
// LOCK_N correct successor samples, flags loss of lock and counts laps.
module ring_monitor #(
    parameter int LOCK_N = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [3:0]       d,
    output logic [1:0]       idx,
    output logic             valid,
    output logic             locked,
    output logic             err,
    output logic             lap,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] lap_cnt
);

    typedef enum logic [1:0] {
        HUNT,
        CONFIRM,
        LOCKED
    } state_t;

    state_t           state, state_nx;
    logic [3:0]       m, m_nx;
    logic [3:0]       p, p_nx;
    logic [1:0]       idx_nx;
    logic             valid_nx, locked_nx, err_nx, lap_nx;
    logic [CNT_W-1:0] err_cnt_nx, lap_cnt_nx;

    logic             legal;
    logic             is_succ;
    logic [3:0]       succ;
    logic [3:0]       m_inc;
    logic [1:0]       d_pos;

    assign legal   = ($countones(d) == 1);
    assign succ    = {p[0], p[3:1]};
    assign is_succ = legal && (d == succ);
    assign m_inc   = m + 4'd1;

    // Binary position of a one-hot word, MSB first (1000 -> 0).
    always_comb begin
        d_pos = 2'd0;
        unique case (d)
            4'b0100: d_pos = 2'd1;
            4'b0010: d_pos = 2'd2;
            4'b0001: d_pos = 2'd3;
            default: d_pos = 2'd0;
        endcase
    end

    // Next state and next registered outputs for the current sample.
    always_comb begin
        // NOTE: every target gets a hold/idle default first so no path leaves it unassigned (no latch).
        state_nx   = state;
        m_nx       = m;
        p_nx       = p;
        idx_nx     = idx;
        valid_nx   = valid;
        err_nx     = 1'b0;
        lap_nx     = 1'b0;
        err_cnt_nx = err_cnt;
        lap_cnt_nx = lap_cnt;

        if (en) begin
            valid_nx = legal;
            if (legal) idx_nx = d_pos;

            unique case (state)
                HUNT: begin
                    if (legal) begin
                        state_nx = CONFIRM;
                        p_nx     = d;
                        m_nx     = 4'd0;
                    end
                end
                CONFIRM: begin
                    if (is_succ) begin
                        p_nx = d;
                        if (m_inc == 4'(LOCK_N)) begin
                            state_nx = LOCKED;
                            m_nx     = 4'd0;
                        end else begin
                            m_nx = m_inc;
                        end
                    end else if (legal) begin
                        p_nx = d;
                        m_nx = 4'd0;
                    end else begin
                        state_nx = HUNT;
                        m_nx     = 4'd0;
                    end
                end
                LOCKED: begin
                    if (is_succ) begin
                        p_nx = d;
                        if (p == 4'b0001) begin
                            lap_nx     = 1'b1;
                            lap_cnt_nx = lap_cnt + CNT_W'(1);
                        end
                    end else begin
                        state_nx = HUNT;
                        m_nx     = 4'd0;
                        err_nx   = 1'b1;
                        if (err_cnt != '1) err_cnt_nx = err_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = HUNT;
                    m_nx     = 4'd0;
                end
            endcase
        end

        locked_nx = (state_nx == LOCKED);
    end

    // State and output registers; clr overrides any sample on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (clr) begin
            state   <= HUNT;
            m       <= 4'd0;
            p       <= 4'd0;
            idx     <= 2'd0;
            valid   <= 1'b0;
            locked  <= 1'b0;
            err     <= 1'b0;
            lap     <= 1'b0;
            err_cnt <= '0;
            lap_cnt <= '0;
        end else begin
            state   <= state_nx;
            m       <= m_nx;
            p       <= p_nx;
            idx     <= idx_nx;
            valid   <= valid_nx;
            locked  <= locked_nx;
            err     <= err_nx;
            lap     <= lap_nx;
            err_cnt <= err_cnt_nx;
            lap_cnt <= lap_cnt_nx;
        end
    end

endmodule

// File: tb/tb_ring_monitor.sv
// tb_ring_monitor: three ring_monitor instances (default, 2-bit counters,
// LOCK_N=1) driven with the same stimulus and checked every cycle against
// a behavioural model, plus directed scenarios with literal expectations.
module tb_ring_monitor;

    logic       clk = 1'b0;
    logic       clr, en;
    logic [3:0] d;

    always #5 clk = ~clk;

    logic [1:0] idx_o    [3];
    logic       valid_o  [3];
    logic       locked_o [3];
    logic       err_o    [3];
    logic       lap_o    [3];
    logic [7:0] ecnt0, lcnt0, ecnt2, lcnt2;
    logic [1:0] ecnt1, lcnt1;

    ring_monitor #(.LOCK_N(3), .CNT_W(8)) u_def (
        .clk(clk), .clr(clr), .en(en), .d(d),
        .idx(idx_o[0]), .valid(valid_o[0]), .locked(locked_o[0]),
        .err(err_o[0]), .lap(lap_o[0]), .err_cnt(ecnt0), .lap_cnt(lcnt0));

    ring_monitor #(.LOCK_N(3), .CNT_W(2)) u_sat (
        .clk(clk), .clr(clr), .en(en), .d(d),
        .idx(idx_o[1]), .valid(valid_o[1]), .locked(locked_o[1]),
        .err(err_o[1]), .lap(lap_o[1]), .err_cnt(ecnt1), .lap_cnt(lcnt1));

    ring_monitor #(.LOCK_N(1), .CNT_W(8)) u_fast (
        .clk(clk), .clr(clr), .en(en), .d(d),
        .idx(idx_o[2]), .valid(valid_o[2]), .locked(locked_o[2]),
        .err(err_o[2]), .lap(lap_o[2]), .err_cnt(ecnt2), .lap_cnt(lcnt2));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] rot(input logic [3:0] w);
        return {w[0], w[3:1]};
    endfunction

    function automatic bit one_hot(input logic [3:0] w);
        return $countones(w) == 1;
    endfunction

    // ---------------- behavioural model ----------------
    int         lock_n [3] = '{3, 3, 1};
    int         cmax   [3] = '{255, 3, 255};
    bit         inited = 1'b0;
    bit         hv     [3];   // a legal word has been seen since hunting began
    bit         lk     [3];
    int         streak [3];
    logic [3:0] pw     [3];
    int         e_idx  [3];
    bit         e_valid[3], e_err[3], e_lap[3];
    int         e_ecnt [3], e_lcnt[3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            e_err[k] = 1'b0;
            e_lap[k] = 1'b0;
            if (clr) begin
                hv[k] = 0; lk[k] = 0; streak[k] = 0; pw[k] = 4'd0;
                e_idx[k] = 0; e_valid[k] = 0; e_ecnt[k] = 0; e_lcnt[k] = 0;
            end else if (en) begin
                e_valid[k] = one_hot(d);
                if (one_hot(d))
                    for (int b = 0; b < 4; b++) if (d[b]) e_idx[k] = 3 - b;
                if (lk[k]) begin
                    if (one_hot(d) && d == rot(pw[k])) begin
                        if (pw[k] == 4'b0001) begin
                            e_lap[k]  = 1'b1;
                            e_lcnt[k] = (e_lcnt[k] + 1) % (cmax[k] + 1);
                        end
                        pw[k] = d;
                    end else begin
                        lk[k] = 0; hv[k] = 0; streak[k] = 0;
                        e_err[k] = 1'b1;
                        if (e_ecnt[k] < cmax[k]) e_ecnt[k]++;
                    end
                end else if (!one_hot(d)) begin
                    hv[k] = 0; streak[k] = 0;
                end else if (!hv[k]) begin
                    hv[k] = 1; streak[k] = 0; pw[k] = d;
                end else if (d == rot(pw[k])) begin
                    streak[k]++;
                    pw[k] = d;
                    if (streak[k] >= lock_n[k]) begin
                        lk[k] = 1; streak[k] = 0;
                    end
                end else begin
                    streak[k] = 0; pw[k] = d;
                end
            end
        end
        if (clr) inited = 1'b1;
    end

    // Compare every instance against the model once outputs are defined.
    always @(negedge clk) begin
        if (inited) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("u%0d.idx", k),    int'(idx_o[k]),    e_idx[k]);
                check($sformatf("u%0d.valid", k),  int'(valid_o[k]),  int'(e_valid[k]));
                check($sformatf("u%0d.locked", k), int'(locked_o[k]), int'(lk[k]));
                check($sformatf("u%0d.err", k),    int'(err_o[k]),    int'(e_err[k]));
                check($sformatf("u%0d.lap", k),    int'(lap_o[k]),    int'(e_lap[k]));
            end
            check("u0.err_cnt", int'(ecnt0), e_ecnt[0]);
            check("u0.lap_cnt", int'(lcnt0), e_lcnt[0]);
            check("u1.err_cnt", int'(ecnt1), e_ecnt[1]);
            check("u1.lap_cnt", int'(lcnt1), e_lcnt[1]);
            check("u2.err_cnt", int'(ecnt2), e_ecnt[2]);
            check("u2.lap_cnt", int'(lcnt2), e_lcnt[2]);
        end
    end

    // Apply one set of inputs and return 1 time unit after the edge that takes them.
    task automatic sample(input logic c, input logic e, input logic [3:0] dd);
        clr = c; en = e; d = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic lock_seq();
        sample(0, 1, 4'b1000);
        sample(0, 1, 4'b0100);
        sample(0, 1, 4'b0010);
        sample(0, 1, 4'b0001);
    endtask

    logic [3:0] cur, nd;
    int         r;

    initial begin
        clr = 1'b1; en = 1'b0; d = 4'd0;
        // reset state
        sample(1, 1, 4'b0100);
        check("rst.idx", int'(idx_o[0]), 0);
        check("rst.valid", int'(valid_o[0]), 0);
        check("rst.locked", int'(locked_o[0]), 0);
        check("rst.err_cnt", int'(ecnt0), 0);

        // lock after 4 samples with LOCK_N=3
        sample(0, 1, 4'b1000);
        sample(0, 1, 4'b0100);
        sample(0, 1, 4'b0010);
        check("lock.early", int'(locked_o[0]), 0);
        sample(0, 1, 4'b0001);
        check("lock.locked", int'(locked_o[0]), 1);
        check("lock.idx", int'(idx_o[0]), 3);
        check("lock.err_cnt", int'(ecnt0), 0);

        // lap
        sample(0, 1, 4'b1000);
        check("lap.pulse", int'(lap_o[0]), 1);
        check("lap.cnt1", int'(lcnt0), 1);
        check("lap.idx", int'(idx_o[0]), 0);
        sample(0, 1, 4'b0100);
        check("lap.clear", int'(lap_o[0]), 0);
        sample(0, 1, 4'b0010);
        sample(0, 1, 4'b0001);
        sample(0, 1, 4'b1000);
        check("lap.cnt2", int'(lcnt0), 2);
        check("lap.cnt2_sat", int'(lcnt1), 2);

        // error: locked at 0100, skip to 0001
        sample(0, 1, 4'b0100);
        sample(0, 1, 4'b0001);
        check("err.pulse", int'(err_o[0]), 1);
        check("err.locked", int'(locked_o[0]), 0);
        check("err.cnt", int'(ecnt0), 1);
        check("err.idx", int'(idx_o[0]), 3);
        sample(0, 1, 4'b0110);
        check("err.valid", int'(valid_o[0]), 0);
        check("err.idx_hold", int'(idx_o[0]), 3);
        check("err.once", int'(err_o[0]), 0);

        // saturation of a 2-bit error counter
        for (int i = 0; i < 3; i++) begin
            lock_seq();
            sample(0, 1, 4'b0000);
        end
        check("sat.cnt_sat", int'(ecnt1), 3);
        check("sat.cnt_def", int'(ecnt0), 4);
        lock_seq();
        sample(0, 1, 4'b0000);
        check("sat.cnt_hold", int'(ecnt1), 3);
        check("sat.cnt_def5", int'(ecnt0), 5);

        // en gaps hold lock
        lock_seq();
        for (int i = 0; i < 10; i++) begin
            sample(0, 0, 4'b0000);
            check("stall.locked", int'(locked_o[0]), 1);
            check("stall.err", int'(err_o[0]), 0);
        end
        sample(0, 1, 4'b1000);
        check("stall.lap", int'(lap_o[0]), 1);

        // clr wins over a wrap
        sample(0, 1, 4'b0100);
        sample(0, 1, 4'b0010);
        sample(0, 1, 4'b0001);
        check("prio.pre", int'(locked_o[0]), 1);
        sample(1, 1, 4'b1000);
        check("prio.lap", int'(lap_o[0]), 0);
        check("prio.lap_cnt", int'(lcnt0), 0);
        check("prio.locked", int'(locked_o[0]), 0);
        check("prio.valid", int'(valid_o[0]), 0);
        check("prio.idx", int'(idx_o[0]), 0);

        // LOCK_N=1
        sample(0, 1, 4'b0010);
        check("fast.first", int'(locked_o[2]), 0);
        sample(0, 1, 4'b0001);
        check("fast.locked", int'(locked_o[2]), 1);
        sample(1, 0, 4'b0000);
        sample(0, 1, 4'b0010);
        sample(0, 1, 4'b0010);
        check("fast.repeat_lock", int'(locked_o[2]), 0);
        check("fast.repeat_err", int'(err_o[2]), 0);
        sample(0, 1, 4'b0001);
        check("fast.relock", int'(locked_o[2]), 1);

        // randomized phase, biased towards legal successor runs
        cur = 4'b0001;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 75)      nd = rot(cur);
            else if (r < 83) nd = cur;
            else if (r < 91) nd = 4'($urandom_range(0, 15));
            else             nd = 4'b0001 << $urandom_range(0, 3);
            if (one_hot(nd)) cur = nd;
            sample(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8), nd);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
